mac_operand_feeder: RTL and testbench

- Upstream stage of mac_unit. It buffers a stream of signed int8 operand pairs (A, B), grouped into vectors by a last flag.
- It issues one pair at a time to mac_unit using mac_unit's valid/done protocol, then waits for each MAC to finish.
- At the end of each vector it reports the dot-product result and the element count over a valid/ready output.
- mac_unit's accumulator is never cleared between vectors. The feeder therefore reports the accumulator delta: y at end of vector minus y at start of vector.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/operand_fifo.sv | 49 ++++
 rtl/mac_operand_feeder.sv | 127 ++++++++++++
 tb/tb_mac_operand_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand feeder and its FIFO.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int FIFO_W = 2 * DATA_W + 1;

  typedef enum logic [2:0] {
    FETCH,
    ISSUE,
    WAIT,
    SETTLE,
    RESULT
  } feeder_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO for operand pairs; an extra pointer bit tells full from empty.
module operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FIFO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds buffered int8 operand pairs to mac_unit one at a time and reports
// each vector's dot product as the accumulator delta across the vector.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              mac_valid,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic              mac_done,
  input  logic [ACC_W-1:0]  mac_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [LEN_W-1:0]  res_count,
  output logic              busy
);

  localparam logic [LEN_W-1:0] CNT_ONE = 1;

  feeder_state_t    state;
  operand_t         push_word;
  operand_t         head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             ready_q;
  logic             last_q;
  logic             first_q;
  logic [ACC_W-1:0] baseline;
  logic [LEN_W-1:0] count;

  assign push_word = '{last: in_last, a: in_a, b: in_b};
  assign in_ready  = ready_q && !full;
  assign pop       = (state == FETCH) && !empty;
  assign busy      = (state != FETCH) || !empty;

  operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Keeps in_ready low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b1;
      baseline  <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!empty) begin
            mac_a     <= head.a;
            mac_b     <= head.b;
            last_q    <= head.last;
            mac_valid <= 1'b1;
            state     <= ISSUE;
            if (first_q) begin
              baseline <= mac_y;
              first_q  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          mac_valid <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mac_done) state <= SETTLE;
        end
        // mac_y has absorbed the product by now; the delta is wrap-safe.
        SETTLE: begin
          count <= count + CNT_ONE;
          if (last_q) begin
            res_data  <= mac_y - baseline;
            res_count <= count + CNT_ONE;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            state <= FETCH;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            count     <= '0;
            first_q   <= 1'b1;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural mac_unit model
// (LOAD cycle, done in the third WAIT cycle, mac_y updated the cycle after).
module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        mac_valid;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_done;
  logic [31:0] mac_y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_count;
  logic        busy;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  logic [31:0] acc = 32'd0;
  int          pipe = 0;
  int          ma = 0;
  int          mb = 0;
  logic        model_done = 1'b0;
  logic        inject_done = 1'b0;
  logic        load_acc = 1'b0;
  logic [31:0] load_val = 32'd0;

  logic [7:0] pulse_a[$];
  logic [7:0] pulse_b[$];
  int         pulse_cyc[$];

  mac_operand_feeder #(.DEPTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_valid (mac_valid),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_done  (mac_done),
    .mac_y     (mac_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign mac_done = model_done | inject_done;
  assign mac_y    = acc;

  always @(posedge clk) cyc <= cyc + 1;

  // mac_unit model: never reset by the feeder, so an in-flight op completes.
  always @(posedge clk) begin
    if (load_acc) acc <= load_val;
    if (pipe == 0 && mac_valid) begin
      ma   <= int'($signed(mac_a));
      mb   <= int'($signed(mac_b));
      pipe <= 1;
    end else if (pipe == 1) begin
      pipe <= 2;
    end else if (pipe == 2) begin
      model_done <= 1'b1;
      pipe       <= 3;
    end else if (pipe == 3) begin
      model_done <= 1'b0;
      acc        <= acc + 32'(ma * mb);
      pipe       <= 0;
    end
  end

  always @(negedge clk) begin
    if (mac_valid) begin
      pulse_a.push_back(mac_a);
      pulse_b.push_back(mac_b);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input logic last);
    int k = 0;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("push_accepted", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResValid(input int maxc);
    int k = 0;
    while (!res_valid && k < maxc) begin
      @(negedge clk);
      k++;
    end
    checkOutput("res_valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic setAcc(input logic [31:0] v);
    load_val = v;
    load_acc = 1'b1;
    @(negedge clk);
    load_acc = 1'b0;
  endtask

  logic [15:0] seq_exp[9] = '{16'h0102, 16'hFD04, 16'h05FA, 16'h0708, 16'hF7F6,
                              16'h0B0C, 16'h0DF2, 16'hF110, 16'h1112};

  initial begin
    int bad;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("reset_mac_valid", {31'd0, mac_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("init_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset asserted mid-WAIT with three pairs still buffered.
    res_ready = 1'b1;
    applyStimulus(1, 1, 1'b0);
    applyStimulus(2, 2, 1'b0);
    applyStimulus(3, 3, 1'b0);
    applyStimulus(4, 4, 1'b1);
    checkOutput("pre_reset_mac_a", {24'd0, mac_a}, 32'd1);
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
    checkOutput("rst_mac_a", {24'd0, mac_a}, 32'd0);
    checkOutput("rst_mac_b", {24'd0, mac_b}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    checkOutput("rst_res_count", {24'd0, res_count}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    pulse_a.delete(); pulse_b.delete(); pulse_cyc.delete();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("stale_done_no_mac_valid", pulse_a.size(), 32'd0);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Fresh accumulator; two vectors back to back.
    setAcc(32'd0);
    applyStimulus(3, 4, 1'b0);
    applyStimulus(-2, 5, 1'b0);
    applyStimulus(127, 127, 1'b1);
    applyStimulus(-128, -128, 1'b1);
    waitResValid(200);
    checkOutput("v1_res_data", res_data, 32'd16131);
    checkOutput("v1_res_count", {24'd0, res_count}, 32'd3);
    checkOutput("v1_pulses", pulse_a.size(), 32'd3);
    if (pulse_cyc.size() >= 3) begin
      checkOutput("v1_gap0", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd6);
      checkOutput("v1_gap1", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd6);
      checkOutput("v1_last_a", {24'd0, pulse_a[2]}, 32'h7F);
    end
    @(negedge clk);
    waitResValid(200);
    checkOutput("v2_res_data", res_data, 32'd16384);
    checkOutput("v2_res_count", {24'd0, res_count}, 32'd1);
    @(negedge clk);

    // Baseline near the top of the range so the accumulator wraps.
    repeat (4) @(negedge clk);
    setAcc(32'h7FFF_FFF0);
    applyStimulus(100, 100, 1'b1);
    waitResValid(200);
    checkOutput("wrap_res_data", res_data, 32'd10000);
    checkOutput("wrap_res_count", {24'd0, res_count}, 32'd1);
    @(negedge clk);

    // Stall the result, fill the FIFO behind it, then drain.
    res_ready = 1'b0;
    applyStimulus(5, 6, 1'b1);
    waitResValid(200);
    checkOutput("hold_res_data", res_data, 32'd30);
    pulse_a.delete(); pulse_b.delete(); pulse_cyc.delete();
    applyStimulus(1, 2, 1'b0);
    applyStimulus(-3, 4, 1'b0);
    applyStimulus(5, -6, 1'b0);
    applyStimulus(7, 8, 1'b0);
    applyStimulus(-9, -10, 1'b0);
    applyStimulus(11, 12, 1'b0);
    applyStimulus(13, -14, 1'b0);
    applyStimulus(-15, 16, 1'b0);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    bad = 0;
    in_valid = 1'b1;
    in_a     = 8'd17;
    in_b     = 8'd18;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 32'd30 || res_count !== 8'd1 || in_ready !== 1'b0) bad++;
    end
    checkOutput("hold_stable", 32'(bad), 32'd0);
    checkOutput("hold_no_mac_valid", pulse_a.size(), 32'd0);
    res_ready = 1'b1;
    applyStimulus(17, 18, 1'b1);
    waitResValid(300);
    checkOutput("fifo_res_data", res_data, 32'd122);
    checkOutput("fifo_res_count", {24'd0, res_count}, 32'd9);
    checkOutput("fifo_pulses", pulse_a.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < pulse_a.size())
        checkOutput($sformatf("fifo_seq%0d", i), {16'd0, pulse_a[i], pulse_b[i]}, {16'd0, seq_exp[i]});
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
